dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 169 ++++++++++++++++
 tb/tb_dmem_responder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Wait-stated, handshaked data-memory responder for the dmem port.
//            Optional byte-lane write enables under DMEM_RESP_BYTE_EN.
// Revision : 1.0  initial release
// ============================================================================
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 4096,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  wren,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data,
`ifdef DMEM_RESP_BYTE_EN
    input  logic [DATA_WIDTH/8-1:0] byte_en,
`endif
    output logic [DATA_WIDTH-1:0] q,
    output logic                  ready,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NBYTES = DATA_WIDTH / 8;
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  wren_q, wren_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] q_q, q_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;
`ifdef DMEM_RESP_BYTE_EN
    logic [NBYTES-1:0]     be_q, be_d;
`endif

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  in_range;
    logic                  commit;
    logic                  mem_we;
    logic [IDX_W-1:0]      mem_idx;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Range test is done on the full latched address so upper bits matter.
    assign in_range  = ({1'b0, addr_q} < DEPTH_LIM);
    assign mem_idx   = addr_q[IDX_W-1:0];
    assign mem_rdata = mem[mem_idx];
    assign commit    = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign mem_we    = commit && wren_q && in_range;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wren_d  = wren_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        q_d     = q_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        busy_d  = busy_q;
`ifdef DMEM_RESP_BYTE_EN
        be_d    = be_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    wren_d  = wren;
                    addr_d  = address;
                    wdata_d = data;
`ifdef DMEM_RESP_BYTE_EN
                    be_d    = byte_en;
`endif
                    cnt_d   = WAIT_LOAD;
                    busy_d  = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    // Commit edge: response registered, FSM back in IDLE so the
                    // ready cycle can accept the next request.
                    if (!wren_q) begin
                        q_d = in_range ? mem_rdata : '0;
                    end
                    ready_d = 1'b1;
                    err_d   = ~in_range;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wren_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            q_q     <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef DMEM_RESP_BYTE_EN
            be_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wren_q  <= wren_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            q_q     <= q_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
`ifdef DMEM_RESP_BYTE_EN
            be_q    <= be_d;
`endif
        end
    end

    // Storage is intentionally not reset; a reset mid-request leaves
    // state_q in IDLE, so no pending write can reach the array.
    always_ff @(posedge clock) begin
        if (mem_we) begin
`ifdef DMEM_RESP_BYTE_EN
            for (int b = 0; b < NBYTES; b++) begin
                if (be_q[b]) begin
                    mem[mem_idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
`else
            mem[mem_idx] <= wdata_q;
`endif
        end
    end

    assign q     = q_q;
    assign ready = ready_q;
    assign err   = err_q;
    assign busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Directed self-checking bench for dmem_responder (DEPTH=1024, 2 WS).
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

    localparam int unsigned AW  = 12;
    localparam int unsigned DW  = 32;
    localparam int unsigned DEP = 1024;
    localparam int unsigned WS  = 2;

    logic          clock   = 1'b0;
    logic          reset   = 1'b0;
    logic          req     = 1'b0;
    logic          wren    = 1'b0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] data    = '0;
    logic [3:0]    byte_en = 4'hF;
    logic [DW-1:0] q;
    logic          ready;
    logic          busy;
    logic          err;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    dmem_responder #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEP),
        .WAIT_STATES(WS)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .req    (req),
        .wren   (wren),
        .address(address),
        .data   (data),
`ifdef DMEM_RESP_BYTE_EN
        .byte_en(byte_en),
`endif
        .q      (q),
        .ready  (ready),
        .busy   (busy),
        .err    (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [3:0] be);
        req     = 1'b1;
        wren    = w;
        address = a;
        data    = d;
        byte_en = be;
        @(posedge clock);
        @(negedge clock);
        req = 1'b0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    // Returns at the negedge of the ready cycle.
    task automatic wait_ready(input string tag, input logic [DW-1:0] exp_q, input logic exp_err);
        int n = 0;
        while (ready !== 1'b1 && n < 20) begin
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            @(negedge clock);
            n++;
        end
        check({tag, "_latency"}, n, WS + 1);
        check({tag, "_ready"}, {31'd0, ready}, 32'd1);
        check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
        check({tag, "_q"}, q, exp_q);
        check({tag, "_busy_clr"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int pulses;
        logic [DW-1:0] q_seen;

        repeat (2) @(negedge clock);
        check("rst_q", q, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // Write then back-to-back read in the ready cycle
        issue(1'b1, 12'h010, 32'hDEADBEEF, 4'hF);
        wait_ready("wr010", 32'h0, 1'b0);
        issue(1'b0, 12'h010, 32'h0, 4'hF);
        wait_ready("rd010", 32'hDEADBEEF, 1'b0);
        @(negedge clock);
        check("ready_one_cycle", {31'd0, ready}, 32'd0);
        check("err_idle", {31'd0, err}, 32'd0);
        check("q_held", q, 32'hDEADBEEF);

        // Writes leave q alone
        issue(1'b1, 12'h030, 32'h11111111, 4'hF);
        wait_ready("wr030", 32'hDEADBEEF, 1'b0);

        // Request pulsed while busy must be ignored
        issue(1'b0, 12'h010, 32'h0, 4'hF);
        req = 1'b1; wren = 1'b1; address = 12'h030; data = 32'h99999999;
        @(negedge clock);
        req = 1'b0;
        pulses = 0;
        q_seen = '0;
        for (int i = 0; i < 8; i++) begin
            if (ready === 1'b1) begin
                pulses++;
                q_seen = q;
            end
            @(negedge clock);
        end
        check("busy_ignore_pulses", pulses, 32'd1);
        check("busy_ignore_q", q_seen, 32'hDEADBEEF);
        issue(1'b0, 12'h030, 32'h0, 4'hF);
        wait_ready("rd030", 32'h11111111, 1'b0);

        // Range boundary: 0x400 out, 0x3FF in
        issue(1'b1, 12'h400, 32'hCAFEBABE, 4'hF);
        wait_ready("wr400", 32'h11111111, 1'b1);
        issue(1'b0, 12'h400, 32'h0, 4'hF);
        wait_ready("rd400", 32'h0, 1'b1);
        issue(1'b1, 12'h3FF, 32'h0BADF00D, 4'hF);
        wait_ready("wr3ff", 32'h0, 1'b0);
        issue(1'b0, 12'h3FF, 32'h0, 4'hF);
        wait_ready("rd3ff", 32'h0BADF00D, 1'b0);

        // Reset during WAIT aborts the write
        issue(1'b1, 12'h020, 32'hA5A5A5A5, 4'hF);
        wait_ready("wr020", 32'h0BADF00D, 1'b0);
        issue(1'b1, 12'h020, 32'h12345678, 4'hF);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("abort_q", q, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_ready", {31'd0, ready}, 32'd0);
        check("abort_err", {31'd0, err}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (ready === 1'b1) pulses++;
        end
        check("abort_no_ready", pulses, 32'd0);
        issue(1'b0, 12'h020, 32'h0, 4'hF);
        wait_ready("rd020", 32'hA5A5A5A5, 1'b0);

`ifdef DMEM_RESP_BYTE_EN
        issue(1'b1, 12'h040, 32'hAABBCCDD, 4'hF);
        wait_ready("be_wr_full", 32'hA5A5A5A5, 1'b0);
        issue(1'b1, 12'h040, 32'h11223344, 4'b0101);
        wait_ready("be_wr_0101", 32'hA5A5A5A5, 1'b0);
        issue(1'b0, 12'h040, 32'h0, 4'h0);
        wait_ready("be_rd", 32'hAA22CC44, 1'b0);
        issue(1'b1, 12'h040, 32'hFFFFFFFF, 4'h0);
        wait_ready("be_wr_none", 32'hAA22CC44, 1'b0);
        issue(1'b0, 12'h040, 32'h0, 4'hF);
        wait_ready("be_rd_none", 32'hAA22CC44, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
